beta_dmem_io: RTL and testbench
===============================

# beta_dmem_io

Data-side memory responder for the beta core: sits on the far end of the core's data bus (`memAddr`, `memWriteData`, `MemRead`, `MemWrite` in; `memReadData` out). It contains a word-addressed data RAM and a memory-mapped interval timer whose interrupt drives the core's `irq` input. Reads are combinational, so the core sees data in the same cycle it issues the address. Writes and all timer state update on the clock edge.

## Interface
- `DEPTH_WORDS`, default 256: data RAM depth in 32-bit words; must be a power of 2.
- `IO_BASE`, default 32'hFFFF_FF00: base of the 256-byte I/O window, decoded on `memAddr[31:8]`.

- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `memAddr` input 32: byte address from the core's ALU.
- `memWriteData` input 32: store data.
- `MemRead` input 1: load strobe.
- `MemWrite` input 1: store strobe.
- `memReadData` output 32: load data (combinational).
- `irq` output 1: timer interrupt request to the core.

## Operation
- Decode: `memAddr[31:8] == IO_BASE[31:8]` selects I/O; otherwise RAM.
- Byte offset `memAddr[1:0]` is ignored everywhere.
- RAM index is `memAddr[log2(DEPTH_WORDS)+1:2]`. Upper bits are ignored, so out-of-range addresses alias modulo the depth.
- RAM store: on an edge with `MemWrite`=1 and RAM selected, write `memWriteData`. RAM contents are not affected by `reset` and are undefined after power-up.
- I/O registers (offset = `memAddr[7:0]`):
  - 0x00 COUNT: read-only current count; writes are ignored.
  - 0x04 LOAD: read/write. Writing it also loads COUNT with the same value on that edge.
  - 0x08 CTRL: read/write, bits [2:0]; upper bits read 0.
    - bit0 EN: timer running.
    - bit1 IE: interrupt enable.
    - bit2 AR: auto-reload.
  - 0x0C STATUS: bit0 PEND; upper bits read 0. Write-1-to-clear: writing bit0=1 clears PEND, writing 0 has no effect.
  - Any other offset: reads return 0; writes are ignored.
- Timer: on each edge with EN=1 and no write to LOAD on that edge:
  - If COUNT != 0: COUNT <= COUNT-1.
  - If COUNT == 0: PEND <= 1. If AR=1, COUNT <= LOAD and EN stays 1. If AR=0, COUNT stays 0 and EN <= 0.
- `irq` = PEND & IE, combinational from registers. `irq` stays high until software clears PEND or IE.
- `memReadData`:
  - Selected RAM word or I/O register when `MemRead`=1.
  - 32'd0 when `MemRead`=0.
- `MemRead` and `MemWrite` both high: the read returns the old contents and the write takes effect at the edge.

## Timing
- Reset values: COUNT=0, LOAD=0, CTRL=0, PEND=0. Consequently `irq`=0, and `memReadData`=0 whenever `MemRead`=0.
- Read latency is 0 cycles (combinational path from address and strobes). Write latency is 1 edge.
- Expiry timing with LOAD=N and EN set:
  - PEND rises N+1 edges after COUNT was loaded with N.
  - With AR=1 the expiry period is N+1 cycles.
  - With LOAD=0 and AR=1, PEND sets on every edge.
- Simultaneous events on one edge:
  - Expiry and STATUS W1C: set wins, PEND=1.
  - Expiry and CTRL write: the CTRL write value wins for EN, and PEND still sets.
  - LOAD write while running: the load wins over the decrement.
- `reset` asserted mid-count clears all timer state on that edge. Any write presented in the same cycle is dropped, for both registers and RAM.
- Clearing EN freezes COUNT. Setting EN again resumes from the frozen value.

## Test plan
- Reset: assert `reset` 1 cycle -> `irq`=0; reading 0x00, 0x04, 0x08, 0x0C returns 0. With `MemRead`=0, `memReadData`=0.
- RAM: store 32'hDEADBEEF at 0x10 and 32'h12345678 at 0x13F0, then load 0x10, 0x12 and 0x3F0 (DEPTH_WORDS=256) -> 32'hDEADBEEF, 32'hDEADBEEF, 32'h12345678 (aliasing).
- One-shot: LOAD=3, CTRL=3'b011 -> COUNT reads 2,1,0 on the following cycles. PEND=1 and `irq`=1 on the 4th edge after the LOAD write; CTRL.EN reads 0 afterwards.
- Auto-reload: LOAD=4, CTRL=3'b111 -> PEND sets every 5 cycles. W1C on STATUS drops `irq` the next cycle; W1C on the exact expiry edge leaves PEND=1.
- IE masking: run with IE=0 -> PEND=1 and `irq`=0. Then write CTRL IE=1 -> `irq`=1 the cycle after.
- Reset mid-count: LOAD=100, run 10 cycles, then assert `reset` together with a LOAD write -> COUNT=0, CTRL=0, no `irq` afterwards.

Source files
------------

// File: rtl/beta_dmem_io.sv
// beta_dmem_io: data-side memory responder for the beta core.
// Word-addressed data RAM plus a memory-mapped interval timer whose
// pending-and-enabled state drives the core's irq input.
// Reads are combinational; stores and timer state update on the rising edge.
module beta_dmem_io #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [31:0] IO_BASE     = 32'hFFFF_FF00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] memAddr,
   input  logic [31:0] memWriteData,
   input  logic        MemRead,
   input  logic        MemWrite,
   output logic [31:0] memReadData,
   output logic        irq
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // I/O register offsets inside the 256-byte window
   localparam logic [7:0] OFF_COUNT  = 8'h00;
   localparam logic [7:0] OFF_LOAD   = 8'h04;
   localparam logic [7:0] OFF_CTRL   = 8'h08;
   localparam logic [7:0] OFF_STATUS = 8'h0C;

   logic [31:0]   r_mem [DEPTH_WORDS];
   logic [31:0]   r_count;
   logic [31:0]   r_load;
   logic          r_en;
   logic          r_ie;
   logic          r_ar;
   logic          r_pend;

   logic          w_io_sel;
   logic [AW-1:0] w_idx;
   logic [7:0]    w_off;
   logic          w_wr_ram;
   logic          w_wr_load;
   logic          w_wr_ctrl;
   logic          w_wr_status;
   logic          w_tick;
   logic          w_expire;
   logic [31:0]   w_io_data;
   logic [31:0]   w_rd_data;
   logic          w_unused;

   assign w_io_sel    = (memAddr[31:8] == IO_BASE[31:8]);
   assign w_idx       = memAddr[AW+1:2];
   assign w_off       = memAddr[7:0];
   // Byte lane bits are not part of any decode.
   assign w_unused    = &{1'b0, memAddr[1:0]};

   assign w_wr_ram    = MemWrite & ~w_io_sel;
   assign w_wr_load   = MemWrite &  w_io_sel & (w_off == OFF_LOAD);
   assign w_wr_ctrl   = MemWrite &  w_io_sel & (w_off == OFF_CTRL);
   assign w_wr_status = MemWrite &  w_io_sel & (w_off == OFF_STATUS);

   // A LOAD write on the same edge overrides the timer's own update.
   assign w_tick      = r_en & ~w_wr_load;
   assign w_expire    = w_tick & (r_count == 32'd0);

   assign irq         = r_pend & r_ie;
   assign memReadData = w_rd_data;

   // RAM store port; a store presented during reset is dropped, contents are never cleared.
   always_ff @(posedge clk) begin
      if (!reset && w_wr_ram) begin
         r_mem[w_idx] <= memWriteData;
      end
   end

   // Timer registers: LOAD/COUNT, CTRL bits and the sticky PEND flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 32'd0;
         r_load  <= 32'd0;
         r_en    <= 1'b0;
         r_ie    <= 1'b0;
         r_ar    <= 1'b0;
         r_pend  <= 1'b0;
      end else begin
         if (w_wr_load) begin
            r_load  <= memWriteData;
            r_count <= memWriteData;
         end else if (w_tick) begin
            if (r_count != 32'd0) begin
               r_count <= r_count - 32'd1;
            end else if (r_ar) begin
               r_count <= r_load;
            end else begin
               r_count <= 32'd0;
            end
         end

         // A CTRL write takes precedence over the one-shot auto-disable.
         if (w_wr_ctrl) begin
            r_en <= memWriteData[0];
            r_ie <= memWriteData[1];
            r_ar <= memWriteData[2];
         end else if (w_expire && !r_ar) begin
            r_en <= 1'b0;
         end

         // Expiry beats a simultaneous write-1-to-clear.
         if (w_expire) begin
            r_pend <= 1'b1;
         end else if (w_wr_status && memWriteData[0]) begin
            r_pend <= 1'b0;
         end
      end
   end

   // Combinational load data: I/O register or RAM word, zero when not reading.
   always_comb begin
      w_io_data = 32'd0;
      w_rd_data = 32'd0;
      case (w_off)
         OFF_COUNT:  w_io_data = r_count;
         OFF_LOAD:   w_io_data = r_load;
         OFF_CTRL:   w_io_data = {29'd0, r_ar, r_ie, r_en};
         OFF_STATUS: w_io_data = {31'd0, r_pend};
         default:    w_io_data = 32'd0;
      endcase
      if (MemRead) begin
         if (w_io_sel) begin
            w_rd_data = w_io_data;
         end else begin
            w_rd_data = r_mem[w_idx];
         end
      end else begin
         w_rd_data = 32'd0;
      end
   end

endmodule

// File: tb/tb_beta_dmem_io.sv
// Directed self-checking bench for beta_dmem_io.
module tb_beta_dmem_io;

   localparam logic [31:0] IO     = 32'hFFFF_FF00;
   localparam logic [31:0] A_CNT  = IO + 32'h00;
   localparam logic [31:0] A_LOAD = IO + 32'h04;
   localparam logic [31:0] A_CTRL = IO + 32'h08;
   localparam logic [31:0] A_STAT = IO + 32'h0C;

   logic        clk;
   logic        reset;
   logic [31:0] memAddr;
   logic [31:0] memWriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] memReadData;
   logic        irq;

   int n_tests = 0;
   int n_fail  = 0;

   beta_dmem_io #(.DEPTH_WORDS(256), .IO_BASE(32'hFFFF_FF00)) dut (
      .clk          (clk),
      .reset        (reset),
      .memAddr      (memAddr),
      .memWriteData (memWriteData),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .memReadData  (memReadData),
      .irq          (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Store one word; consumes one clock edge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      memAddr      = a;
      memWriteData = d;
      MemWrite     = 1'b1;
      MemRead      = 1'b0;
      @(posedge clk);
      #1;
      MemWrite     = 1'b0;
   endtask

   // Combinational read and check; consumes no edge.
   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      memAddr = a;
      MemRead = 1'b1;
      #1;
      chk(tag, memReadData, exp);
      MemRead = 1'b0;
      #1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; memAddr = 32'd0; memWriteData = 32'd0;
      MemRead = 1'b0; MemWrite = 1'b0;
      tick(2);
      reset = 1'b0;

      // reset state
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_noread", memReadData, 32'd0);
      rd_chk("rst_count", A_CNT, 32'd0);
      rd_chk("rst_load", A_LOAD, 32'd0);
      rd_chk("rst_ctrl", A_CTRL, 32'd0);
      rd_chk("rst_stat", A_STAT, 32'd0);

      // RAM and aliasing
      wr(32'h0000_0010, 32'hDEADBEEF);
      wr(32'h0000_13F0, 32'h12345678);
      rd_chk("ram_10", 32'h0000_0010, 32'hDEADBEEF);
      rd_chk("ram_12", 32'h0000_0012, 32'hDEADBEEF);
      rd_chk("ram_alias", 32'h0000_03F0, 32'h12345678);
      memAddr = 32'h0000_0010; MemRead = 1'b0; #1;
      chk("ram_noread", memReadData, 32'd0);
      rd_chk("io_unmapped", IO + 32'h10, 32'd0);
      wr(A_CNT, 32'h0000_0055);
      rd_chk("count_ro", A_CNT, 32'd0);

      // simultaneous read and write: old data visible, new after edge
      memAddr = 32'h0000_0020; memWriteData = 32'hA5A5_0001; MemRead = 1'b1; MemWrite = 1'b1;
      wr(32'h0000_0020, 32'h1111_2222);
      memAddr = 32'h0000_0020; memWriteData = 32'h3333_4444; MemRead = 1'b1; MemWrite = 1'b1; #1;
      chk("rw_old", memReadData, 32'h1111_2222);
      @(posedge clk); #1; MemWrite = 1'b0; MemRead = 1'b0;
      rd_chk("rw_new", 32'h0000_0020, 32'h3333_4444);

      // one-shot: EN+IE, then LOAD=3 on the next edge
      wr(A_CTRL, 32'h0000_0003);
      wr(A_LOAD, 32'd3);
      rd_chk("os_c3", A_CNT, 32'd3);
      tick(1); rd_chk("os_c2", A_CNT, 32'd2);
      tick(1); rd_chk("os_c1", A_CNT, 32'd1);
      tick(1); rd_chk("os_c0", A_CNT, 32'd0);
      chk("os_irq_early", {31'd0, irq}, 32'd0);
      tick(1);
      chk("os_irq", {31'd0, irq}, 32'd1);
      rd_chk("os_pend", A_STAT, 32'd1);
      rd_chk("os_ctrl", A_CTRL, 32'd2);
      tick(2); rd_chk("os_hold0", A_CNT, 32'd0);
      wr(A_STAT, 32'd0);
      chk("os_w0", {31'd0, irq}, 32'd1);
      wr(A_STAT, 32'd1);
      chk("os_clr", {31'd0, irq}, 32'd0);

      // auto-reload: LOAD=4, period 5
      wr(A_LOAD, 32'd4);
      wr(A_CTRL, 32'h0000_0007);
      tick(4);
      rd_chk("ar_c0", A_CNT, 32'd0);
      chk("ar_irq_early", {31'd0, irq}, 32'd0);
      tick(1);
      chk("ar_irq1", {31'd0, irq}, 32'd1);
      rd_chk("ar_reload", A_CNT, 32'd4);
      rd_chk("ar_ctrl", A_CTRL, 32'd7);
      wr(A_STAT, 32'd1);
      chk("ar_w1c", {31'd0, irq}, 32'd0);
      rd_chk("ar_c3", A_CNT, 32'd3);
      tick(3);
      rd_chk("ar_c0b", A_CNT, 32'd0);
      wr(A_STAT, 32'd1);
      chk("ar_setwins", {31'd0, irq}, 32'd1);
      rd_chk("ar_c4b", A_CNT, 32'd4);
      wr(A_CTRL, 32'd0);
      rd_chk("frz_c3", A_CNT, 32'd3);
      tick(3);
      rd_chk("frz_hold", A_CNT, 32'd3);
      wr(A_STAT, 32'd1);
      chk("ar_clr", {31'd0, irq}, 32'd0);

      // IE masking: EN only, count frozen at 3
      wr(A_CTRL, 32'h0000_0001);
      tick(1); rd_chk("ie_resume", A_CNT, 32'd2);
      tick(3);
      rd_chk("ie_pend", A_STAT, 32'd1);
      chk("ie_masked", {31'd0, irq}, 32'd0);
      wr(A_CTRL, 32'h0000_0002);
      chk("ie_unmask", {31'd0, irq}, 32'd1);

      // reset mid-count with a simultaneous LOAD write and RAM write
      wr(A_LOAD, 32'd100);
      wr(A_CTRL, 32'h0000_0003);
      tick(10);
      rd_chk("mid_c90", A_CNT, 32'd90);
      reset = 1'b1;
      wr(A_LOAD, 32'd55);
      wr(32'h0000_0010, 32'hCAFEF00D);
      reset = 1'b0;
      rd_chk("mr_count", A_CNT, 32'd0);
      rd_chk("mr_load", A_LOAD, 32'd0);
      rd_chk("mr_ctrl", A_CTRL, 32'd0);
      rd_chk("mr_stat", A_STAT, 32'd0);
      rd_chk("mr_ram", 32'h0000_0010, 32'hDEADBEEF);
      tick(5);
      chk("mr_irq", {31'd0, irq}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
